// File: rtl/cosim_axil_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cosim_axil_master: co-simulation strobe bus to AXI4-Lite master bridge,    |
// | one AXI transaction per request, with completion timeout.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cosim_axil_master #(
  parameter int unsigned TIMEOUT  = 1024,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic [31:0] ADDR,
  input  logic [31:0] WRDAT,
  input  logic        WR,
  input  logic        RD,
  output logic        WRREADY,
  output logic        RDREADY,
  output logic [31:0] RDDAT,
  output logic        ERR,
  output logic        BUSY,
  output logic [31:0] M_AXI_AWADDR,
  output logic [2:0]  M_AXI_AWPROT,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WREQ  = 3'd1,
    WRESP = 3'd2,
    RREQ  = 3'd3,
    RRESP = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rddat_q, rddat_d;
  logic [31:0] cnt_q, cnt_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        bready_q, bready_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        wrready_q, wrready_d;
  logic        rdready_q, rdready_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        is_rd_q, is_rd_d;
  logic        timeout_hit;
  logic        abort;

  // >= rather than == so a state change landing on the limit cycle still aborts
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= TIMEOUT);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rddat_d   = rddat_q;
    cnt_d     = cnt_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    wrready_d = 1'b0;
    rdready_d = 1'b0;
    err_d     = err_q;
    busy_d    = busy_q;
    is_rd_d   = is_rd_q;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        if (WR) begin
          addr_d    = ADDR;
          wdata_d   = WRDAT;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          is_rd_d   = 1'b0;
          err_d     = 1'b0;
          cnt_d     = 32'd0;
          busy_d    = 1'b1;
          state_d   = WREQ;
        end else if (RD) begin
          addr_d    = ADDR;
          arvalid_d = 1'b1;
          is_rd_d   = 1'b1;
          err_d     = 1'b0;
          cnt_d     = 32'd0;
          busy_d    = 1'b1;
          state_d   = RREQ;
        end
      end
      WREQ: begin
        cnt_d     = cnt_q + 32'd1;
        awvalid_d = awvalid_q & ~M_AXI_AWREADY;
        wvalid_d  = wvalid_q & ~M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WRESP;
        end else begin
          abort = timeout_hit;
        end
      end
      WRESP: begin
        cnt_d = cnt_q + 32'd1;
        if (M_AXI_BVALID) begin
          bready_d  = 1'b0;
          err_d     = |M_AXI_BRESP;
          wrready_d = 1'b1;
          state_d   = DONE;
        end else begin
          abort = timeout_hit;
        end
      end
      RREQ: begin
        cnt_d = cnt_q + 32'd1;
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RRESP;
        end else begin
          abort = timeout_hit;
        end
      end
      RRESP: begin
        cnt_d = cnt_q + 32'd1;
        if (M_AXI_RVALID) begin
          rready_d  = 1'b0;
          rddat_d   = (M_AXI_RRESP == 2'b00) ? M_AXI_RDATA : ERR_DATA;
          err_d     = |M_AXI_RRESP;
          rdready_d = 1'b1;
          state_d   = DONE;
        end else begin
          abort = timeout_hit;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Timeout drops every handshake signal even mid-handshake
    if (abort) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      err_d     = 1'b1;
      wrready_d = ~is_rd_q;
      rdready_d = is_rd_q;
      if (is_rd_q) rddat_d = ERR_DATA;
      state_d = DONE;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      rddat_q   <= 32'd0;
      cnt_q     <= 32'd0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      wrready_q <= 1'b0;
      rdready_q <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      is_rd_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rddat_q   <= rddat_d;
      cnt_q     <= cnt_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      wrready_q <= wrready_d;
      rdready_q <= rdready_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      is_rd_q   <= is_rd_d;
    end
  end

  assign WRREADY       = wrready_q;
  assign RDREADY       = rdready_q;
  assign RDDAT         = rddat_q;
  assign ERR           = err_q;
  assign BUSY          = busy_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_cosim_axil_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cosim_axil_master: bench for cosim_axil_master with a delay-programmable |
// | AXI4-Lite slave and a latency/response reference model.                     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_cosim_axil_master;

  localparam int          TO    = 16;
  localparam logic [31:0] EDATA = 32'hDEADBEEF;
  localparam logic [7:0]  NEVER = 8'hFF;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] ADDR = '0, WRDAT = '0;
  logic        WR = 1'b0, RD = 1'b0;
  logic        WRREADY, RDREADY, ERR, BUSY;
  logic [31:0] RDDAT;
  logic [31:0] AWADDR, WDATA, ARADDR;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic        s_awready, s_wready, s_arready, s_bvalid, s_rvalid;

  // slave configuration for the current transaction
  logic [7:0]  aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  bresp_cfg = 0, rresp_cfg = 0;
  logic [31:0] rdata_cfg = 0;

  always #5 ACLK = ~ACLK;

  cosim_axil_master #(.TIMEOUT(TO), .ERR_DATA(EDATA)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ADDR(ADDR), .WRDAT(WRDAT), .WR(WR), .RD(RD),
    .WRREADY(WRREADY), .RDREADY(RDREADY), .RDDAT(RDDAT), .ERR(ERR), .BUSY(BUSY),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWPROT(AWPROT), .M_AXI_AWVALID(AWVALID),
    .M_AXI_AWREADY(s_awready), .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB),
    .M_AXI_WVALID(WVALID), .M_AXI_WREADY(s_wready), .M_AXI_BRESP(bresp_cfg),
    .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(BREADY), .M_AXI_ARADDR(ARADDR),
    .M_AXI_ARPROT(ARPROT), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(s_arready),
    .M_AXI_RDATA(rdata_cfg), .M_AXI_RRESP(rresp_cfg), .M_AXI_RVALID(s_rvalid),
    .M_AXI_RREADY(RREADY)
  );

  // Slave: READY after VALID has waited <dly> cycles; responses <dly> cycles after request
  logic [7:0] aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic       aw_got, w_got, b_pend, r_pend;
  wire aw_hs = AWVALID && s_awready;
  wire w_hs  = WVALID && s_wready;
  wire ar_hs = ARVALID && s_arready;
  assign s_awready = AWVALID && aw_dly != NEVER && aw_cnt >= aw_dly;
  assign s_wready  = WVALID && w_dly != NEVER && w_cnt >= w_dly;
  assign s_arready = ARVALID && ar_dly != NEVER && ar_cnt >= ar_dly;
  assign s_bvalid  = b_pend && b_cnt == 0;
  assign s_rvalid  = r_pend && r_cnt == 0;

  always @(posedge ACLK or posedge ARESET) begin
    if (ARESET || !BUSY) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
    end else begin
      if (AWVALID && !s_awready) aw_cnt <= aw_cnt + 1;
      if (WVALID && !s_wready) w_cnt <= w_cnt + 1;
      if (ARVALID && !s_arready) ar_cnt <= ar_cnt + 1;
      if (aw_hs) aw_got <= 1;
      if (w_hs) w_got <= 1;
      if ((aw_got || aw_hs) && (w_got || w_hs) && (aw_hs || w_hs) && b_dly != NEVER) begin
        b_pend <= 1; b_cnt <= b_dly; aw_got <= 0; w_got <= 0;
      end else if (b_pend && b_cnt != 0) b_cnt <= b_cnt - 1;
      if (s_bvalid && BREADY) b_pend <= 0;
      if (ar_hs && r_dly != NEVER) begin
        r_pend <= 1; r_cnt <= r_dly;
      end else if (r_pend && r_cnt != 0) r_cnt <= r_cnt - 1;
      if (s_rvalid && RREADY) r_pend <= 0;
    end
  end

  // Monitor: cumulative handshake counts, captured request fields, protocol observations
  int aw_n = 0, w_n = 0, ar_n = 0, viol_n = 0, wrp_n = 0, rdp_n = 0;
  logic [31:0] cap_awaddr = 0, cap_wdata = 0, cap_araddr = 0;
  logic [3:0]  cap_wstrb = 0;
  logic [2:0]  cap_prot = 0;
  logic        aw_prev = 0, w_prev = 0, ar_prev = 0;
  always @(posedge ACLK) begin
    if (aw_hs) begin aw_n <= aw_n + 1; cap_awaddr <= AWADDR; cap_prot <= AWPROT; end
    if (w_hs) begin w_n <= w_n + 1; cap_wdata <= WDATA; cap_wstrb <= WSTRB; end
    if (ar_hs) begin ar_n <= ar_n + 1; cap_araddr <= ARADDR; end
    aw_prev <= aw_hs; w_prev <= w_hs; ar_prev <= ar_hs;
    viol_n <= viol_n + int'(aw_prev && AWVALID) + int'(w_prev && WVALID) + int'(ar_prev && ARVALID);
    wrp_n <= wrp_n + int'(WRREADY);
    rdp_n <= rdp_n + int'(RDREADY);
  end

  int checks = 0, failures = 0;
  logic [31:0] exp_rddat = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One request; expectations come from a latency/response model of the slave settings
  task automatic run_txn(input bit is_wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] d3,
                         input logic [1:0] resp, input bit collide, input bit extra_wr);
    bit never, exp_err;
    int exp_lat, n, aw0, w0, ar0, v0, wp0, rp0;
    if (is_wr) begin
      aw_dly = d1; w_dly = d2; b_dly = d3; bresp_cfg = resp;
      never = (d1 == NEVER) || (d2 == NEVER) || (d3 == NEVER);
      exp_lat = never ? TO + 2 : 3 + ((d1 > d2) ? int'(d1) : int'(d2)) + int'(d3);
    end else begin
      ar_dly = d1; r_dly = d2; rresp_cfg = resp; rdata_cfg = data;
      never = (d1 == NEVER) || (d2 == NEVER);
      exp_lat = never ? TO + 2 : 3 + int'(d1) + int'(d2);
    end
    exp_err = never || (resp != 2'b00);
    if (!is_wr) exp_rddat = exp_err ? EDATA : data;
    aw0 = aw_n; w0 = w_n; ar0 = ar_n; v0 = viol_n; wp0 = wrp_n; rp0 = rdp_n;
    @(posedge ACLK); #1;
    ADDR = addr; WRDAT = data; WR = is_wr; RD = !is_wr || collide;
    @(posedge ACLK); #1;
    WR = 0; RD = 0; n = 1;
    chk("busy_after_accept", 32'(BUSY), 32'd1);
    while (!(is_wr ? WRREADY : RDREADY) && n < 64) begin
      WR = extra_wr && n == 2;
      ADDR = ~addr;
      @(posedge ACLK); #1;
      n++;
    end
    WR = 0;
    chk("ready_latency", 32'(n), 32'(exp_lat));
    chk("err", 32'(ERR), 32'(exp_err));
    chk("other_ready", 32'(is_wr ? RDREADY : WRREADY), 32'd0);
    if (!is_wr) chk("rddat", RDDAT, exp_rddat);
    if (is_wr && !never) begin
      chk("aw_count", 32'(aw_n - aw0), 32'd1);
      chk("w_count", 32'(w_n - w0), 32'd1);
      chk("awaddr", cap_awaddr, addr);
      chk("wdata", cap_wdata, data);
      chk("wstrb_prot", {25'd0, cap_prot, cap_wstrb}, 32'h0000000F);
    end
    if (!is_wr && !never) begin
      chk("ar_count", 32'(ar_n - ar0), 32'd1);
      chk("araddr", cap_araddr, addr);
    end
    chk(is_wr ? "no_ar_on_write" : "no_aw_on_read", 32'(is_wr ? ar_n - ar0 : aw_n - aw0), 32'd0);
    chk("valid_drop_after_hs", 32'(viol_n - v0), 32'd0);
    @(posedge ACLK); #1;
    chk("pulse_one_cycle", {30'd0, WRREADY, RDREADY}, 32'd0);
    chk("busy_after_done", 32'(BUSY), 32'd0);
    chk("handshake_outputs_idle", {27'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 32'd0);
    chk("rddat_hold", RDDAT, exp_rddat);
    chk("pulse_count", 32'(is_wr ? wrp_n - wp0 : rdp_n - rp0), 32'd1);
  endtask

  initial begin
    int wp0;
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_handshake", {27'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 32'd0);
    chk("rst_flags", {28'd0, WRREADY, RDREADY, ERR, BUSY}, 32'd0);
    chk("rst_rddat", RDDAT, 32'd0);
    chk("rst_addr_data", AWADDR | ARADDR | WDATA, 32'd0);
    ARESET = 0;

    run_txn(1, 32'h40000000, 32'h00000003, 0, 0, 0, 2'b00, 0, 0);
    run_txn(0, 32'h40000010, 32'h12345678, 0, 5, 0, 2'b00, 0, 0);
    run_txn(1, 32'h40000020, 32'hA5A5A5A5, 4, 0, 0, 2'b10, 0, 0);
    run_txn(0, 32'h40000030, 32'h0BADF00D, NEVER, 0, 0, 2'b00, 0, 0);
    run_txn(1, 32'h40000040, 32'h11112222, 1, 2, 1, 2'b00, 1, 0);
    run_txn(1, 32'h40000050, 32'h33334444, 2, 1, 2, 2'b00, 0, 1);
    run_txn(1, 32'h40000060, 32'h55556666, 0, 0, NEVER, 2'b00, 0, 0);
    run_txn(0, 32'h40000070, 32'h77778888, 1, 1, 0, 2'b11, 0, 0);

    // reset while waiting for the write response
    aw_dly = 0; w_dly = 0; b_dly = NEVER;
    @(posedge ACLK); #1;
    ADDR = 32'h50000000; WRDAT = 32'hCAFEBABE; WR = 1;
    @(posedge ACLK); #1;
    WR = 0;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    chk("wresp_bready", 32'(BREADY), 32'd1);
    #2 ARESET = 1;
    #1;
    chk("async_rst_handshake", {27'd0, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 32'd0);
    chk("async_rst_flags", {28'd0, WRREADY, RDREADY, ERR, BUSY}, 32'd0);
    chk("async_rst_regs", AWADDR | WDATA | RDDAT, 32'd0);
    exp_rddat = 0;
    wp0 = wrp_n;
    @(posedge ACLK); @(posedge ACLK); #1;
    ARESET = 0;
    repeat (TO + 6) @(posedge ACLK);
    #1;
    chk("no_wrready_after_rst", 32'(wrp_n - wp0), 32'd0);
    run_txn(0, 32'h50000004, 32'h600DD00D, 0, 0, 0, 2'b00, 0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [7:0] d[3];
      bit wr;
      wr = 1'($urandom);
      for (int k = 0; k < 3; k++) d[k] = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 7) == 0) d[$urandom_range(0, wr ? 2 : 1)] = NEVER;
      run_txn(wr, $urandom, $urandom, d[0], d[1], d[2],
              ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
